// File: rtl/fila_pkg.sv
// Shared constants for the read queue and its pointer counters.
package fila_pkg;

    localparam int WIDTH_DFLT = 4;
    localparam int DEPTH_DFLT = 4;
    localparam int PTR_W      = $clog2(DEPTH_DFLT);

endpackage

// File: rtl/ponteiro_fila.sv
// Wrap-around pointer counter for the queue; advances when enabled.
module ponteiro_fila #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fila_leitura_4bits.sv
// Show-ahead FIFO between the datapath result and its consumer,
// with sticky overflow/underflow flags.
module fila_leitura_4bits
    import fila_pkg::*;
#(
    parameter int WIDTH = WIDTH_DFLT,
    parameter int DEPTH = DEPTH_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int LP_PW = $clog2(DEPTH);
    localparam int LP_CW = LP_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LP_CW-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;

    logic [LP_PW-1:0] w_wr_ptr;
    logic [LP_PW-1:0] w_rd_ptr;
    logic             w_full;
    logic             w_valid;
    logic             w_wr;
    logic             w_pop;

    assign w_full  = (r_count == LP_CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_wr    = wr_en & ~w_full;
    assign w_pop   = w_valid & rd_ready;

    ponteiro_fila #(.W(LP_PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr),
        .o_ptr (w_wr_ptr)
    );

    ponteiro_fila #(.W(LP_PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pop),
        .o_ptr (w_rd_ptr)
    );

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + LP_CW'(1);
                2'b01:   r_count <= r_count - LP_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_ready && !w_valid) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign full     = w_full;
    assign rd_valid = w_valid;
    assign rd_data  = r_mem[w_rd_ptr];
    assign count    = r_count;
    assign ovf      = r_ovf;
    assign udf      = r_udf;

endmodule

// File: tb/tb_fila_leitura_4bits.sv
// Directed bench for fila_leitura_4bits with hand-computed expectations.
module tb_fila_leitura_4bits;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       full;
    logic       rd_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [2:0] count;
    logic       ovf;
    logic       udf;

    int n_vec;
    int n_err;

    fila_leitura_4bits #(.WIDTH(4), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 4'h0;
        rd_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_udf", 32'(udf), 32'd0);
        reset = 1'b1;

        // fill
        push(4'h1);
        chk("fill1_valid", 32'(rd_valid), 32'd1);
        chk("fill1_data", 32'(rd_data), 32'h1);
        chk("fill1_count", 32'(count), 32'd1);
        push(4'h2);
        push(4'h3);
        chk("fill3_full", 32'(full), 32'd0);
        push(4'h4);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_count", 32'(count), 32'd4);

        // overflow
        push(4'hF);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(rd_data), 32'h1);

        // drain
        rd_ready = 1'b1;
        tick();
        chk("drain_2", 32'(rd_data), 32'h2);
        chk("drain_cnt3", 32'(count), 32'd3);
        tick();
        chk("drain_3", 32'(rd_data), 32'h3);
        tick();
        chk("drain_4", 32'(rd_data), 32'h4);
        tick();
        rd_ready = 1'b0;
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_udf", 32'(udf), 32'd0);

        // underflow
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("udf_flag", 32'(udf), 32'd1);
        chk("udf_count", 32'(count), 32'd0);
        push(4'h5);
        chk("udf_wr_valid", 32'(rd_valid), 32'd1);
        chk("udf_wr_data", 32'(rd_data), 32'h5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("udf_pop_cnt", 32'(count), 32'd0);

        // simultaneous push and pop
        push(4'h6);
        push(4'h7);
        chk("sim_cnt", 32'(count), 32'd2);
        wr_en    = 1'b1;
        wr_data  = 4'h8;
        rd_ready = 1'b1;
        tick();
        wr_en    = 1'b0;
        chk("sim_cnt2", 32'(count), 32'd2);
        chk("sim_b", 32'(rd_data), 32'h7);
        tick();
        chk("sim_c", 32'(rd_data), 32'h8);
        chk("sim_cnt1", 32'(count), 32'd1);
        tick();
        rd_ready = 1'b0;
        chk("sim_empty", 32'(rd_valid), 32'd0);

        // wrap-around
        for (int i = 0; i < 10; i++) begin
            push(4'(i));
            chk("wrap_data", 32'(rd_data), 32'(i));
            chk("wrap_cnt", 32'(count), 32'd1);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            chk("wrap_cnt0", 32'(count), 32'd0);
        end

        // write while full with a pop on the same edge is dropped
        push(4'h9);
        push(4'hA);
        push(4'hB);
        push(4'hC);
        wr_en    = 1'b1;
        wr_data  = 4'hE;
        rd_ready = 1'b1;
        tick();
        wr_en    = 1'b0;
        chk("fullpop_cnt", 32'(count), 32'd3);
        chk("fullpop_head", 32'(rd_data), 32'hA);
        tick();
        chk("fullpop_b", 32'(rd_data), 32'hB);
        tick();
        chk("fullpop_c", 32'(rd_data), 32'hC);
        tick();
        rd_ready = 1'b0;
        chk("fullpop_empty", 32'(count), 32'd0);

        // reset mid-operation
        push(4'h1);
        push(4'h2);
        push(4'h3);
        chk("mid_cnt3", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(rd_valid), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);
        chk("mid_udf", 32'(udf), 32'd0);
        #1 reset = 1'b1;
        push(4'hA);
        chk("mid_wr_valid", 32'(rd_valid), 32'd1);
        chk("mid_wr_data", 32'(rd_data), 32'hA);
        chk("mid_wr_cnt", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fila_leitura_4bits.md
FILA_LEITURA_4BITS -- requirements
Module: fila_leitura_4bits

Interface
REQ-001 Parameter: WIDTH, default 4, data word width in bits.
REQ-002 Parameter: DEPTH, default 4, number of storage entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 Port: wr_en  input  1  write request from the producer (datapath/ALU result side).
REQ-006 Port: wr_data  input  WIDTH  word to store when a write is accepted.
REQ-007 Port: full  output  1  high when count equals DEPTH.
REQ-008 Port: rd_ready  input  1  consumer can accept the word on rd_data.
REQ-009 Port: rd_valid  output  1  rd_data holds the oldest stored word.
REQ-010 Port: rd_data  output  WIDTH  oldest word (show-ahead); held stable while rd_valid=1 and rd_ready=0.
REQ-011 Port: count  output  clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012 Port: ovf  output  1  sticky flag: a write was attempted while full.
REQ-013 Port: udf  output  1  sticky flag: rd_ready was asserted while rd_valid=0.

Function
REQ-014 A write is accepted on a rising edge when wr_en=1 and full=0; wr_data goes into the entry at the write pointer, and the write pointer advances modulo DEPTH.
REQ-015 A pop occurs on a rising edge when rd_valid=1 and rd_ready=1; the read pointer advances modulo DEPTH.
REQ-016 rd_valid is 1 when and only when count>0; rd_data is the entry at the read pointer.
REQ-017 Write-to-read latency is one cycle: a word written into an empty queue shows rd_valid=1 and that word on rd_data immediately after the accepting edge.
REQ-018 count update per edge: +1 on write only, -1 on pop only, unchanged on both or neither.
REQ-019 Simultaneous write and pop with 0<count<DEPTH: both are performed, and the order of all other words is preserved.
REQ-020 A write while full is dropped, even if a pop happens on the same edge; ovf is set to 1, and storage and the write pointer stay unchanged.
REQ-021 rd_ready=1 while empty pops nothing and sets udf to 1; a write on the same edge is still accepted.
REQ-022 Pointers wrap from DEPTH-1 to 0 with no gap or lost word; words come out in strict FIFO order across the wrap.
REQ-023 ovf and udf stay at 1 until reset; there is no other way to clear them.
REQ-024 Storage contents are not reset; only pointers, count, and flags are reset. Stale contents never appear with rd_valid=1.

Reset
REQ-025 While reset=0, regardless of clk: read and write pointers = 0, count = 0, full = 0, rd_valid = 0, ovf = 0, udf = 0.
REQ-026 Reset asserted mid-operation discards every stored word; the first valid output after release is the first word written after release.
REQ-027 Release of reset is synchronous to clk; the first write can be accepted on the first rising edge with reset=1.

Structure
REQ-028 Shared package fila_pkg defines the WIDTH and DEPTH default constants and the pointer width PTR_W = clog2(DEPTH).
REQ-029 Sub-module ponteiro_fila is a PTR_W-bit wrap-around counter with enable and the same asynchronous active-low reset. It is instantiated twice: once for the write pointer and once for the read pointer.
REQ-030 count is a separate register. It is not derived from pointer difference.

Verification
REQ-031 Fill and drain: write 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles with rd_ready=0 -> full=1, count=4. Then hold rd_ready=1 -> rd_data goes 1, 2, 3, 4 on successive cycles, after which rd_valid=0 and count=0.
REQ-032 Overflow: with the queue full, write 4'hF -> ovf=1, count=4, and the drained sequence is still 1, 2, 3, 4 with no 4'hF.
REQ-033 Underflow: with the queue empty, rd_ready=1 for one cycle -> udf=1, count=0. Then write 4'h5 -> rd_valid=1 and rd_data=4'h5 on the next cycle.
REQ-034 Simultaneous push and pop: with count=2 holding A, B, write C while popping A -> count=2, rd_data=B, then C.
REQ-035 Wrap-around: perform 10 single write/pop pairs with data 0..9 -> output order is 0..9 and count never exceeds 1.
REQ-036 Reset mid-operation: with count=3, pulse reset=0 between clock edges -> count=0, rd_valid=0, ovf=0, udf=0 immediately. A subsequent write of 4'hA is read back first.
